// File: rtl/wb_intercon.sv
// Shared-bus Wishbone interconnect: N masters, M slaves.
// Registered round-robin grant with cycle lock, lowest-index mask/base decode,
// and a watchdog that answers unmapped or stalled strobes with a one-cycle err.
module wb_intercon #(
    parameter int                        num_masters = 4,
    parameter int                        num_slaves  = 8,
    parameter logic [32*num_slaves-1:0]  slave_base  = {num_slaves{32'h0}},
    parameter logic [32*num_slaves-1:0]  slave_mask  = {num_slaves{32'h0}},
    parameter int                        timeout     = 1024
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [32*num_masters-1:0]    m_adr_i,
    input  logic [32*num_masters-1:0]    m_dat_i,
    input  logic [4*num_masters-1:0]     m_sel_i,
    input  logic [num_masters-1:0]       m_we_i,
    input  logic [num_masters-1:0]       m_cyc_i,
    input  logic [num_masters-1:0]       m_stb_i,
    output logic [31:0]                  m_dat_o,
    output logic [num_masters-1:0]       m_ack_o,
    output logic [num_masters-1:0]       m_err_o,
    output logic [num_masters-1:0]       m_rty_o,

    output logic [31:0]                  s_adr_o,
    output logic [31:0]                  s_dat_o,
    output logic [3:0]                   s_sel_o,
    output logic                         s_we_o,
    output logic                         s_cyc_o,
    output logic [num_slaves-1:0]        s_stb_o,
    input  logic [32*num_slaves-1:0]     s_dat_i,
    input  logic [num_slaves-1:0]        s_ack_i,
    input  logic [num_slaves-1:0]        s_err_i,
    input  logic [num_slaves-1:0]        s_rty_i,

    output logic [num_masters-1:0]       gnt_o,
    output logic                         wdt_o
);

    localparam int MI_W  = (num_masters > 1) ? $clog2(num_masters) : 1;
    localparam int CNT_W = $clog2(timeout);

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    arb_state_t             state;
    logic [MI_W-1:0]        ptr;

    logic [31:0]            own_adr;
    logic [31:0]            own_dat;
    logic [3:0]             own_sel;
    logic                   own_we;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   owned;

    logic                   rearb;
    logic                   found;
    logic [MI_W-1:0]        nxt_idx;
    logic [num_masters-1:0] nxt_gnt;

    logic [num_slaves-1:0]  hit;
    logic [num_slaves-1:0]  dec_oh;
    logic                   dec_hit;
    logic                   sl_ack;
    logic                   sl_err;
    logic                   sl_rty;

    logic                   err_q;
    logic [CNT_W-1:0]       wd_cnt;
    logic                   term;
    logic                   unmapped;
    logic                   stall;
    logic                   wdt_fire;
    logic                   err_set;

    assign owned = (state == OWNED);

    // Route the current owner's request signals onto the shared bus.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        for (int i = 0; i < num_masters; i++) begin
            if (gnt_o[i]) begin
                own_adr = m_adr_i[32*i +: 32];
                own_dat = m_dat_i[32*i +: 32];
                own_sel = m_sel_i[4*i +: 4];
                own_we  = m_we_i[i];
                own_cyc = m_cyc_i[i];
                own_stb = m_stb_i[i];
            end
        end
    end

    // Pick the first requester after the pointer, wrapping modulo num_masters.
    always_comb begin
        found   = 1'b0;
        nxt_idx = ptr;
        nxt_gnt = '0;
        for (int i = 0; i < num_masters; i++) begin
            if (!found && m_cyc_i[i] && (i > int'(ptr))) begin
                found      = 1'b1;
                nxt_idx    = MI_W'(i);
                nxt_gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < num_masters; i++) begin
            if (!found && m_cyc_i[i] && (i <= int'(ptr))) begin
                found      = 1'b1;
                nxt_idx    = MI_W'(i);
                nxt_gnt[i] = 1'b1;
            end
        end
    end

    // The bus is re-arbitrated when idle or once the owner releases cyc.
    assign rearb = !owned || !own_cyc;

    // Arbiter state machine with registered one-hot grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt_o <= '0;
            ptr   <= MI_W'(num_masters - 1);
        end else if (rearb) begin
            if (found) begin
                state <= OWNED;
                gnt_o <= nxt_gnt;
                ptr   <= nxt_idx;
            end else begin
                state <= IDLE;
                gnt_o <= '0;
            end
        end
    end

    // Address decode; the lowest-index hitting slave wins on overlap.
    always_comb begin
        hit    = '0;
        dec_oh = '0;
        for (int j = 0; j < num_slaves; j++) begin
            hit[j] = ((own_adr & slave_mask[32*j +: 32]) == slave_base[32*j +: 32]);
        end
        for (int j = num_slaves - 1; j >= 0; j--) begin
            if (hit[j] && owned) begin
                dec_oh    = '0;
                dec_oh[j] = 1'b1;
            end
        end
    end

    assign dec_hit = |dec_oh;

    // Read data and terminations from the decoded slave only.
    always_comb begin
        m_dat_o = '0;
        for (int j = 0; j < num_slaves; j++) begin
            if (dec_oh[j]) begin
                m_dat_o = s_dat_i[32*j +: 32];
            end
        end
    end

    assign sl_ack = |(dec_oh & s_ack_i);
    assign sl_err = |(dec_oh & s_err_i);
    assign sl_rty = |(dec_oh & s_rty_i);

    // A pending interconnect error suppresses the strobe and overrides slave ack/rty.
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_we_o  = own_we;
    assign s_cyc_o = own_cyc;
    assign s_stb_o = dec_oh & {num_slaves{own_stb && !err_q}};

    assign m_ack_o = gnt_o & {num_masters{sl_ack && !err_q}};
    assign m_rty_o = gnt_o & {num_masters{sl_rty && !err_q}};
    assign m_err_o = gnt_o & {num_masters{err_q || sl_err}};
    assign wdt_o   = err_q;

    // Any termination seen by the owner restarts the stall count.
    assign term     = sl_ack || sl_err || sl_rty || err_q;
    assign unmapped = owned && own_stb && !(|hit) && !err_q;
    assign stall    = owned && own_stb && dec_hit && !term;
    assign wdt_fire = stall && (wd_cnt == CNT_W'(timeout - 1));
    // Only raise the error if the same owner still holds the bus next cycle.
    assign err_set  = (unmapped || wdt_fire) && !rearb;

    // Watchdog counter and the registered one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q  <= 1'b0;
            wd_cnt <= '0;
        end else begin
            err_q <= err_set;
            if (rearb || term || err_set) begin
                wd_cnt <= '0;
            end else if (stall) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: 4 masters, 4 slaves, 16-cycle watchdog.
module tb_wb_intercon;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam logic [32*NS-1:0] BASE = {32'h7000_0000, 32'h1200_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [32*NS-1:0] MASK = {32'hFFFF_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};

    logic              clk = 1'b0;
    logic              reset;
    logic [32*NM-1:0]  m_adr;
    logic [32*NM-1:0]  m_dat;
    logic [4*NM-1:0]   m_sel;
    logic [NM-1:0]     m_we;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [31:0]       m_dat_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [NM-1:0]     m_rty_o;
    logic [31:0]       s_adr_o;
    logic [31:0]       s_dat_o;
    logic [3:0]        s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic [NS-1:0]     s_stb_o;
    logic [32*NS-1:0]  s_dat;
    logic [NS-1:0]     s_ack;
    logic [NS-1:0]     s_err;
    logic [NS-1:0]     s_rty;
    logic [NM-1:0]     gnt_o;
    logic              wdt_o;

    int n_vec  = 0;
    int n_miss = 0;

    wb_intercon #(
        .num_masters (NM),
        .num_slaves  (NS),
        .slave_base  (BASE),
        .slave_mask  (MASK),
        .timeout     (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .s_rty_i (s_rty),
        .gnt_o   (gnt_o),
        .wdt_o   (wdt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr);
        m_cyc[i]          = cyc;
        m_stb[i]          = stb;
        m_we[i]           = we;
        m_adr[32*i +: 32] = adr;
        m_dat[32*i +: 32] = 32'hA500_0000 | adr[15:0];
        m_sel[4*i +: 4]   = 4'hF;
        #1;
    endtask

    initial begin
        logic [3:0] e;
        reset = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat = {32'hDEAD_BEEF, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        s_ack = '0; s_err = '0; s_rty = '0;
        step();
        step();

        // reset state
        chk("rst_gnt",  gnt_o,   4'b0000);
        chk("rst_wdt",  wdt_o,   1'b0);
        chk("rst_stb",  s_stb_o, 4'b0000);
        chk("rst_cyc",  s_cyc_o, 1'b0);
        chk("rst_term", {m_ack_o, m_err_o, m_rty_o}, 12'h000);
        reset = 1'b0;

        // masters 0 and 2 request together; 0 wins, then handover to 2
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
        set_m(2, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t1_latency", gnt_o, 4'b0000);
        step();
        chk("t1_gnt0", gnt_o, 4'b0001);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t1_gnt2", gnt_o, 4'b0100);
        set_m(2, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("t1_idle", gnt_o, 4'b0000);

        // all masters request; grants rotate from the master after the last owner (2)
        m_cyc = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << ((3 + k) % 4);
            chk($sformatf("t2_rot%0d", k), gnt_o, e);
            if (k < 4) begin
                m_cyc = ~e;
                step();
                m_cyc = 4'b1111;
                #1;
            end
        end
        m_cyc = '0;
        step();
        chk("t2_idle", gnt_o, 4'b0000);

        // decode to slave 3, read data and ack routing
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h7000_0010);
        step();
        chk("t3_gnt", gnt_o, 4'b0010);
        chk("t3_stb", s_stb_o, 4'b1000);
        chk("t3_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("t3_adr", s_adr_o, 32'h7000_0010);
        chk("t3_wdat", s_dat_o, 32'hA500_0010);
        chk("t3_cyc", s_cyc_o, 1'b1);
        s_ack = 4'b1000;
        #1;
        chk("t3_ack", m_ack_o, 4'b0010);
        chk("t3_noerr", m_err_o, 4'b0000);
        s_ack = '0;
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // overlapping decode: slave 1 beats slave 2; slave err routes to owner
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h1200_0000);
        step();
        chk("ov_gnt", gnt_o, 4'b0100);
        chk("ov_stb", s_stb_o, 4'b0010);
        chk("ov_dat", m_dat_o, 32'h2222_0001);
        s_err = 4'b0010;
        s_rty = 4'b0100;
        #1;
        chk("ov_err", m_err_o, 4'b0100);
        chk("ov_rty", m_rty_o, 4'b0000);
        s_err = '0;
        s_rty = '0;
        set_m(2, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // unmapped address
        set_m(3, 1'b1, 1'b1, 1'b0, 32'hF000_0000);
        step();
        chk("t4_gnt", gnt_o, 4'b1000);
        chk("t4_stb", s_stb_o, 4'b0000);
        chk("t4_pre", {m_err_o, wdt_o}, 5'b0000_0);
        step();
        chk("t4_err", {m_err_o, wdt_o}, 5'b1000_1);
        chk("t4_stb_err", s_stb_o, 4'b0000);
        set_m(3, 1'b1, 1'b0, 1'b0, 32'hF000_0000);
        step();
        chk("t4_post", {m_err_o, wdt_o}, 5'b0000_0);
        set_m(3, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // watchdog: slave 0 never acks
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        step();
        chk("t5_gnt", gnt_o, 4'b0001);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t5_wait%0d", k), {m_err_o, wdt_o, s_stb_o}, 9'b0000_0_0001);
            step();
        end
        chk("t5_fire", {m_err_o, wdt_o, s_stb_o}, 9'b0001_1_0000);
        s_ack = 4'b0001;
        #1;
        chk("t5_ack_drop", m_ack_o, 4'b0000);
        s_ack = '0;
        step();
        chk("t5_restart", {m_err_o, wdt_o, s_stb_o}, 9'b0000_0_0001);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // reset in the middle of a granted write
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h1000_0000);
        step();
        chk("t6_gnt", gnt_o, 4'b0010);
        chk("t6_wr", {s_we_o, s_stb_o}, 5'b1_0010);
        reset = 1'b1;
        s_ack = 4'b0010;
        step();
        chk("t6_rst_gnt", gnt_o, 4'b0000);
        chk("t6_rst_stb", {s_cyc_o, s_stb_o}, 5'b0_0000);
        chk("t6_rst_term", {m_ack_o, m_err_o, wdt_o}, 9'h000);
        reset = 1'b0;
        s_ack = '0;
        #1;
        chk("t6_rel", gnt_o, 4'b0000);
        step();
        chk("t6_regnt", gnt_o, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
